// File: rtl/scan_code_pkg.sv
// ---------------------------------------------------------------------------
// scan_code_pkg
// Shared definitions for the PS/2 scan-code filter: the prefix-tracking
// state enum, the prefix byte values, the Pause discard length and the
// list of keyboard status/reply bytes that never describe a key.
// ---------------------------------------------------------------------------
package scan_code_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } filter_state_t;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

    // Bytes following E1 in the Pause make sequence that are swallowed.
    localparam logic [2:0] PAUSE_DISCARD = 3'd7;

    // Keyboard replies (BAT ok, ack, echo, resend, error/overrun codes).
    localparam int NUM_NON_KEY = 6;
    localparam logic [NUM_NON_KEY-1:0][7:0] NON_KEY_CODES =
        {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    function automatic logic is_non_key(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_NON_KEY; i++) begin
            if (NON_KEY_CODES[i] == b) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PREFIX_EXT) || (b == PREFIX_BRK) || (b == PREFIX_PAUSE);
    endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// ---------------------------------------------------------------------------
// strobe_edge_detect
// Turns a level "byte ready" signal into a single-cycle acceptance pulse on
// its rising edge.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   level  : level input from the upstream byte receiver
//   pulse  : high in the cycle where level is high but was low last cycle
// History resets to 1 so a level already high when reset releases is not
// mistaken for a fresh byte.
// ---------------------------------------------------------------------------
module strobe_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/scan_code_filter.sv
// ---------------------------------------------------------------------------
// scan_code_filter
// Collapses PS/2 set-2 scan-code byte sequences (E0 / F0 / E1 prefixes) into
// single key events.
//   Parameter TIMEOUT_CYCLES : clocks a prefix state may sit idle (>= 2)
//   clk, reset               : clock, asynchronous active-high reset
//   byte_valid, byte_in      : level-valid byte from the PS/2 receiver
//   key_valid                : one-cycle event strobe
//   key_code, key_ext,
//   key_break                : event fields, held until the next event
//   proto_err                : one-cycle pulse on bad prefix or timeout
// Optional feature macro SCAN_FILTER_REPEAT_SUPPRESS_EN: drops typematic
// repeats of the currently held key.
// ---------------------------------------------------------------------------
module scan_code_filter
    import scan_code_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       proto_err
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Firing on the cycle the counter is about to reach TIMEOUT_CYCLES-1
    // makes the error pulse line up with the counter showing that value.
    localparam logic [TO_W-1:0] TIMEOUT_FIRE = TO_W'(TIMEOUT_CYCLES - 2);

    logic            byte_accept;
    filter_state_t   state_q, state_d;
    logic [2:0]      pause_q, pause_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic            ev_fire, ev_ext, ev_brk, err_d, emit;
    logic [7:0]      ev_code;

    strobe_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (byte_valid),
        .pulse (byte_accept)
    );

    // Next-state decode. An accepted byte always takes priority over a
    // timeout in the same cycle, so a late byte is never lost to an error.
    always_comb begin
        state_d   = state_q;
        pause_d   = pause_q;
        timeout_d = timeout_q;
        ev_fire   = 1'b0;
        ev_code   = byte_in;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;
        err_d     = 1'b0;
        if (byte_accept) begin
            timeout_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == PREFIX_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_in == PREFIX_BRK) begin
                        state_d = ST_BRK;
                    end else if (byte_in == PREFIX_PAUSE) begin
                        state_d = ST_PAUSE;
                        pause_d = PAUSE_DISCARD;
                    end else if (!is_non_key(byte_in)) begin
                        ev_fire = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_in == PREFIX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_in != PREFIX_EXT) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (is_prefix(byte_in)) begin
                        err_d = 1'b1;
                    end else begin
                        ev_fire = 1'b1;
                        ev_brk  = 1'b1;
                        ev_ext  = (state_q == ST_EXT_BRK);
                    end
                end
                ST_PAUSE: begin
                    // Pause has no break code; the whole sequence is one event.
                    if (pause_q == 3'd1) begin
                        ev_fire = 1'b1;
                        ev_code = PREFIX_PAUSE;
                        ev_ext  = 1'b1;
                        pause_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        pause_d = pause_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            timeout_d = timeout_q + 1'b1;
            if (timeout_q == TIMEOUT_FIRE) begin
                state_d = ST_IDLE;
                pause_d = '0;
                err_d   = 1'b1;
            end
        end else begin
            timeout_d = '0;
        end
    end

`ifdef SCAN_FILTER_REPEAT_SUPPRESS_EN
    logic       held_valid_q, held_valid_d;
    logic       held_ext_q, held_ext_d;
    logic [7:0] held_code_q, held_code_d;
    logic       is_make, held_match;

    // Typematic repeats of the key currently held are dropped; releasing
    // that key re-arms it. Pause bypasses this since it never breaks.
    always_comb begin
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        emit         = ev_fire;
        is_make      = ev_fire && !ev_brk && (state_q != ST_PAUSE);
        held_match   = held_valid_q && (held_ext_q == ev_ext) && (held_code_q == ev_code);
        if (is_make) begin
            if (held_match) begin
                emit = 1'b0;
            end else begin
                held_valid_d = 1'b1;
                held_ext_d   = ev_ext;
                held_code_d  = ev_code;
            end
        end else if (ev_fire && ev_brk && held_match) begin
            held_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
        end
    end
`else
    assign emit = ev_fire;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pause_q   <= '0;
            timeout_q <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            pause_q   <= pause_d;
            timeout_q <= timeout_d;
            key_valid <= emit;
            proto_err <= err_d;
            if (emit) begin
                key_code  <= ev_code;
                key_ext   <= ev_ext;
                key_break <= ev_brk;
            end
        end
    end

endmodule

// File: tb/tb_scan_code_filter.sv
// ---------------------------------------------------------------------------
// tb_scan_code_filter
// Directed-vector bench for scan_code_filter (TIMEOUT_CYCLES = 16). Expected
// events and errors are queued with the cycle they must appear in; a monitor
// pops and compares whenever key_valid or proto_err is seen.
// Honours SCAN_FILTER_REPEAT_SUPPRESS_EN for the typematic repeat case.
// ---------------------------------------------------------------------------
module tb_scan_code_filter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       proto_err;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    scan_code_filter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drives one byte for a single cycle; optionally queues the response it
    // must produce, lat cycles after the drive point.
    task automatic apply_stimulus(input logic [7:0] b, input logic push, input logic is_err,
                                  input logic [7:0] code, input logic ext, input logic brk,
                                  input int lat);
        exp_t e;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        if (push) begin
            e.is_err = is_err;
            e.code   = code;
            e.ext    = ext;
            e.brk    = brk;
            e.at     = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        apply_stimulus(b, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    endtask

    task automatic send_ev(input logic [7:0] b, input logic [7:0] code, input logic ext, input logic brk);
        apply_stimulus(b, 1'b1, 1'b0, code, ext, brk, 1);
    endtask

    task automatic send_err(input logic [7:0] b, input int lat);
        apply_stimulus(b, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output strobe must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (key_valid || proto_err) begin
            check_output("exclusive", {31'd0, key_valid & proto_err}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe actual=valid%0b/err%0b code=%0h required=none (cycle %0d)",
                         key_valid, proto_err, key_code, cyc);
            end else begin
                e = sb.pop_front();
                check_output("strobe_cycle", cyc, e.at);
                if (e.is_err) begin
                    check_output("err_strobe", {30'd0, proto_err, key_valid}, {30'd0, 2'b10});
                end else begin
                    check_output("event", {20'd0, proto_err, key_valid, key_ext, key_break, key_code},
                                 {20'd0, 1'b0, 1'b1, e.ext, e.brk, e.code});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        idle(3);
        check_output("reset_outputs", {20'd0, proto_err, key_valid, key_ext, key_break, key_code}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Plain make, then the fields must hold with the strobe gone.
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);
        idle(2);
        check_output("hold_fields", {22'd0, key_valid, key_ext, key_break, key_code}, {22'd0, 3'b000, 8'h1C});

        // Extended break.
        send(8'hE0);
        send(8'hF0);
        send_ev(8'h75, 8'h75, 1'b1, 1'b1);

        // Pause sequence: one event after the eighth byte.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        send_ev(8'h77, 8'hE1, 1'b1, 1'b0);

        // Non-key replies are dropped silently.
        send(8'hAA); send(8'h00); send(8'hFA);
        send_ev(8'h2B, 8'h2B, 1'b0, 1'b0);

        // Repeated E0 prefix stays extended.
        send(8'hE0); send(8'hE0);
        send_ev(8'h74, 8'h74, 1'b1, 1'b0);

        // Prefix after F0 / E0 F0 is a protocol error.
        send(8'hF0);
        send_err(8'hE0, 1);
        send(8'hE0); send(8'hF0);
        send_err(8'hF0, 1);

        // Timeout: error 15 clocks after the F0 is accepted, then normal.
        send_err(8'hF0, TO);
        idle(TO + 4);
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);

        // Clear any held key, then typematic repeats.
        send_ev(8'hF0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_back());
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b1);
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);
`ifdef SCAN_FILTER_REPEAT_SUPPRESS_EN
        send(8'h1C);
        send(8'h1C);
`else
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);
`endif
        send(8'hF0);
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b1);
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);
`ifndef SCAN_FILTER_REPEAT_SUPPRESS_EN
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0);
`else
        send(8'h1C);
`endif

        // Reset between E0 and 75 with byte_valid held high across release.
        send(8'hE0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = 8'h75;
        reset      = 1'b1;
        idle(2);
        check_output("reset_mid_outputs", {20'd0, proto_err, key_valid, key_ext, key_break, key_code}, 32'd0);
        reset = 1'b0;
        idle(5);
        byte_valid = 1'b0;
        idle(1);
        send_ev(8'h75, 8'h75, 1'b0, 1'b0);

        idle(5);
        check_output("queue_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_code_filter.md
SCAN_CODE_FILTER -- requirements
Module: scan_code_filter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000, prefix-state idle limit in clk cycles (>=2).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: byte_valid  in  1  level from upstream PS/2 byte receiver (its ready), synchronous to clk.
REQ-005 SHALL have ports: byte_in  in  8  received scan-code byte, stable while byte_valid high.
REQ-006 SHALL have ports: key_valid  out  1  one-cycle event strobe.
REQ-007 SHALL have ports: key_code  out  8  base scan code of event (prefixes stripped).
REQ-008 SHALL have ports: key_ext  out  1  event was E0-prefixed (or Pause).
REQ-009 SHALL have ports: key_break  out  1  event is a release (F0 seen).
REQ-010 SHALL have ports: proto_err  out  1  one-cycle pulse on protocol error or timeout.

Function
REQ-011 Byte accepted only on byte_valid rising edge (low previous cycle, high current cycle N); byte_in sampled at N.
REQ-012 key_valid/key_code/key_ext/key_break SHALL update at N+1; key_valid high exactly one cycle; key_code/ext/break hold until next event.
REQ-013 FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
REQ-014 IDLE: E0->EXT; F0->BRK; E1->PAUSE (discard counter=7); AA/FA/EE/FE/00/FF->IDLE, no event, no error; other->make event (ext=0, break=0), stay IDLE.
REQ-015 EXT: F0->EXT_BRK; E0->stay EXT; other->make event ext=1, ->IDLE.
REQ-016 BRK: other->break event ext=0, ->IDLE; E0/F0/E1->proto_err, ->IDLE, no event.
REQ-017 EXT_BRK: other->break event ext=1, ->IDLE; E0/F0/E1->proto_err, ->IDLE, no event.
REQ-018 PAUSE: each accepted byte decrements counter; on seventh byte emit key_code=E1, ext=1, break=0, ->IDLE; byte values ignored.
REQ-019 Timeout counter clears on every accepted byte and in IDLE; counts in any other state; at TIMEOUT_CYCLES-1 ->IDLE with proto_err pulse, no event.
REQ-020 Accepted byte and timeout in same cycle: byte wins, counter clears, no error.
REQ-021 proto_err and key_valid never asserted in same cycle.

Reset
REQ-022 Reset SHALL force: state IDLE, all outputs 0, counters 0, edge-detect history 1 (byte_valid already high at release is not accepted).
REQ-023 Reset mid-sequence SHALL discard partial prefixes; no event after release until a new rising edge.

Configuration
REQ-024 Macro SCAN_FILTER_REPEAT_SUPPRESS_EN defined: held register {valid,ext,code}; make equal to held key suppressed (no event); unsuppressed make loads held; break matching held clears it; break events always emitted.
REQ-025 Macro undefined: every make emitted, including typematic repeats; no held register.

Structure
REQ-026 Package scan_code_pkg SHALL hold state enum, constants PREFIX_EXT=E0, PREFIX_BRK=F0, PREFIX_PAUSE=E1, PAUSE_DISCARD=7, and the non-key code list.
REQ-027 One sub-module, strobe_edge_detect, SHALL produce the rising-edge pulse from byte_valid.

Verification
REQ-028 Bytes 1C -> one event code=1C ext=0 brk=0 at N+1, one cycle wide.
REQ-029 E0,F0,75 -> single event code=75 ext=1 brk=1; no event for prefixes.
REQ-030 E1,14,77,E1,F0,14,F0,77 -> single event code=E1 ext=1 brk=0 after eighth byte.
REQ-031 F0 then no byte for TIMEOUT_CYCLES (bench uses 16) -> proto_err pulse at cycle 15 after F0, state IDLE; next 1C gives plain make.
REQ-032 With SCAN_FILTER_REPEAT_SUPPRESS_EN: 1C,1C,1C,F0,1C,1C -> make, break, make (three events); without: five events.
REQ-033 Reset asserted between E0 and 75, byte_valid held high across release -> no event until next rising edge; 75 then yields ext=0 make.
